// File: rtl/fifo_queue_if.sv
// fifo_queue_if: producer/consumer handshake bundle for fifo_queue.
// master drives push/pop/data_in; slave returns data, occupancy and flags.
interface fifo_queue_if #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  out_valid;
  logic [CW-1:0]         count;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output push, pop, data_in,
    input  data_out, out_valid, count,
    input  empty, full, almost_empty, almost_full,
    input  overflow, underflow
  );

  modport slave (
    input  push, pop, data_in,
    output data_out, out_valid, count,
    output empty, full, almost_empty, almost_full,
    output overflow, underflow
  );
endinterface

// File: rtl/fifo_queue.sv
// fifo_queue: synchronous FIFO with registered output, occupancy, watermarks
// and sticky overflow/underflow. Ports: clk, rst (sync, active-high), bus.
module fifo_queue #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic        clk,
  input  logic        rst,
  fifo_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  ovalid_q;
  logic                  ovf_q;
  logic                  unf_q;

  logic empty_w;
  logic full_w;
  logic pop_ok;
  logic push_ok;

  assign empty_w = (count == '0);
  assign full_w  = (count == CW'(DEPTH));
  assign pop_ok  = bus.pop && !empty_w;
  // A pop frees the head slot, so a push into a full queue may proceed.
  assign push_ok = bus.push && (!full_w || pop_ok);

  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      dout_q   <= '0;
      ovalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        dout_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      ovalid_q <= pop_ok;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.push && !push_ok) begin
        ovf_q <= 1'b1;
      end
      if (bus.pop && !pop_ok) begin
        unf_q <= 1'b1;
      end
    end
  end

  assign bus.data_out     = dout_q;
  assign bus.out_valid    = ovalid_q;
  assign bus.count        = count;
  assign bus.empty        = empty_w;
  assign bus.full         = full_w;
  assign bus.almost_empty = (count <= CW'(AE_LEVEL));
  assign bus.almost_full  = (count >= CW'(AF_LEVEL));
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_fifo_queue.sv
// tb_fifo_queue: directed + random stimulus against a queue-based model;
// a negedge monitor pops expected words and compares all outputs.
module tb_fifo_queue;
  localparam int DEPTH = 8;
  localparam int DW    = 8;
  localparam int AF    = DEPTH - 1;
  localparam int AE    = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_queue_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) bus ();

  fifo_queue #(
    .DEPTH(DEPTH), .DATA_WIDTH(DW),
    .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [DW-1:0] m_q [$];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] m_dout;
  bit            m_ovf;
  bit            m_unf;
  bit            chk_en = 1'b0;
  int            vecs = 0;
  int            errs = 0;

  task automatic chk(input string name, input int act, input int req);
    vecs++;
    if (act != req) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input bit r, input bit ps, input bit pp,
                      input logic [DW-1:0] d);
    bit pop_ok;
    bit push_ok;
    rst         = r;
    bus.push    = ps;
    bus.pop     = pp;
    bus.data_in = d;
    @(posedge clk);
    if (r) begin
      m_q.delete();
      exp_q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      pop_ok  = pp && (m_q.size() > 0);
      push_ok = ps && ((m_q.size() < DEPTH) || pop_ok);
      if (pop_ok) begin
        m_dout = m_q.pop_front();
        exp_q.push_back(m_dout);
      end
      if (push_ok) m_q.push_back(d);
      if (ps && !push_ok) m_ovf = 1'b1;
      if (pp && !pop_ok) m_unf = 1'b1;
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      int  n;
      bit  ev;
      logic [DW-1:0] e;
      n  = m_q.size();
      ev = (exp_q.size() > 0);
      chk("count", int'(bus.count), n);
      chk("empty", int'(bus.empty), int'(n == 0));
      chk("full", int'(bus.full), int'(n == DEPTH));
      chk("almost_empty", int'(bus.almost_empty), int'(n <= AE));
      chk("almost_full", int'(bus.almost_full), int'(n >= AF));
      chk("overflow", int'(bus.overflow), int'(m_ovf));
      chk("underflow", int'(bus.underflow), int'(m_unf));
      chk("out_valid", int'(bus.out_valid), int'(ev));
      if (ev) begin
        e = exp_q.pop_front();
        chk("pop_data", int'(bus.data_out), int'(e));
      end
      chk("data_out_hold", int'(bus.data_out), int'(m_dout));
    end
  end

  initial begin
    logic [DW-1:0] d;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.data_in = '0;
    step(1, 0, 0, 0);
    chk_en = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // fill then drain in order
    for (int i = 0; i < 8; i++) step(0, 1, 0, DW'(8'h11 + i));
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);

    // overflow: dropped word never emerges
    for (int i = 0; i < 8; i++) step(0, 1, 0, DW'(8'h11 + i));
    step(0, 1, 0, 8'hAA);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);

    // push+pop on empty: no fall-through
    step(1, 0, 0, 0);
    step(0, 1, 1, 8'h5A);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // wrap-around at constant depth 3
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, DW'(i));
    for (int i = 3; i < 23; i++) step(0, 1, 1, DW'(i));
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);

    // full with simultaneous push/pop
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, DW'(8'h21 + i));
    step(0, 1, 1, 8'hC3);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);

    // mid-stream reset coinciding with a pop
    for (int i = 0; i < 5; i++) step(0, 1, 0, DW'(8'h40 + i));
    step(1, 0, 1, 0);
    step(0, 1, 0, 8'h77);
    step(0, 0, 1, 0);

    // random traffic with varying bias and rare resets
    for (int ph = 0; ph < 4; ph++) begin
      int pw;
      int pr;
      pw = (ph % 2 == 0) ? 70 : 30;
      pr = (ph % 2 == 0) ? 30 : 70;
      for (int i = 0; i < 400; i++) begin
        d = DW'($urandom_range(0, 255));
        step(($urandom_range(0, 199) == 0),
             ($urandom_range(0, 99) < pw),
             ($urandom_range(0, 99) < pr), d);
      end
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
